// File: rtl/sao_lcu_scheduler_if.sv
// Stream bundle between the SAO LCU scheduler, its parameter/pixel sources and the SAO filter.
// master = scheduler side, slave = environment (sources + SAO) side.
interface sao_lcu_scheduler_if;
    logic        prm_valid;
    logic        prm_ready;
    logic [1:0]  prm_type;
    logic [4:0]  prm_band_pos;
    logic        prm_eo_class;
    logic [15:0] prm_offset;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_data;
    logic        sao_busy;
    logic        sao_finish;
    logic        in_en;
    logic [7:0]  din;
    logic [1:0]  sao_type;
    logic [4:0]  sao_band_pos;
    logic        sao_eo_class;
    logic [15:0] sao_offset;

    modport master (
        input  prm_valid, prm_type, prm_band_pos, prm_eo_class, prm_offset,
        input  pix_valid, pix_data, sao_busy, sao_finish,
        output prm_ready, pix_ready, in_en, din,
        output sao_type, sao_band_pos, sao_eo_class, sao_offset
    );

    modport slave (
        output prm_valid, prm_type, prm_band_pos, prm_eo_class, prm_offset,
        output pix_valid, pix_data, sao_busy, sao_finish,
        input  prm_ready, pix_ready, in_en, din,
        input  sao_type, sao_band_pos, sao_eo_class, sao_offset
    );
endinterface

// File: rtl/sao_lcu_scheduler.sv
// Frame sequencer in front of the SAO filter: raster LCU walk, per-LCU parameter load, pixel gating.
// Optional busy-stall performance counter enabled by defining SAO_SCHED_STALL_CNT_EN.
module sao_lcu_scheduler #(
    parameter int FRAME_W  = 128,
    parameter int FRAME_H  = 128,
    parameter int DRAIN_TO = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          cfg_lcu_size,
    sao_lcu_scheduler_if.master bus,
    output logic [2:0]          lcu_x,
    output logic [2:0]          lcu_y,
    output logic [1:0]          lcu_size,
    output logic                frame_done,
    output logic                err,
    output logic [15:0]         stall_cnt
);

    localparam int DCW = $clog2(DRAIN_TO) + 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_TO - 1);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

    state_t         state, state_nx;
    logic [12:0]    px_cnt;
    logic [12:0]    lcu_pix;
    logic [2:0]     pos_x, pos_y;
    logic [2:0]     x_last, y_last;
    logic [DCW-1:0] drain_cnt;
    logic           start_ok, start_bad;
    logic           lcu_full, last_lcu, xfer;
    logic           prm_ready_c, pix_ready_c;

    // Index of the last LCU column/row for a frame dimension at the given LCU size.
    function automatic logic [2:0] last_idx(input int dim, input logic [1:0] size);
        return 3'(((dim / 16) >> size) - 1);
    endfunction

    assign lcu_pix   = 13'd256 << {lcu_size, 1'b0};
    assign x_last    = last_idx(FRAME_W, lcu_size);
    assign y_last    = last_idx(FRAME_H, lcu_size);
    assign lcu_full  = (px_cnt == lcu_pix);
    assign last_lcu  = (pos_x == x_last) && (pos_y == y_last);
    assign start_ok  = start && (cfg_lcu_size != 2'd3);
    assign start_bad = start && (cfg_lcu_size == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        prm_ready_c = 1'b0;
        pix_ready_c = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_ok) state_nx = LOAD;
            end
            LOAD: begin
                prm_ready_c = 1'b1;
                if (bus.prm_valid) state_nx = STREAM;
            end
            STREAM: begin
                pix_ready_c = !bus.sao_busy && !lcu_full;
                if (lcu_full) state_nx = last_lcu ? DRAIN : LOAD;
            end
            DRAIN: begin
                if (bus.sao_finish || (drain_cnt == DRAIN_LAST)) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign xfer          = pix_ready_c && bus.pix_valid;
    assign bus.prm_ready = prm_ready_c;
    assign bus.pix_ready = pix_ready_c;

    // Registered SAO-side outputs, LCU walk and drain watchdog.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.in_en        <= 1'b0;
            bus.din          <= '0;
            bus.sao_type     <= '0;
            bus.sao_band_pos <= '0;
            bus.sao_eo_class <= 1'b0;
            bus.sao_offset   <= '0;
            lcu_x            <= '0;
            lcu_y            <= '0;
            lcu_size         <= '0;
            frame_done       <= 1'b0;
            err              <= 1'b0;
            px_cnt           <= '0;
            pos_x            <= '0;
            pos_y            <= '0;
            drain_cnt        <= '0;
        end else begin
            bus.in_en  <= xfer;
            frame_done <= 1'b0;
            err        <= 1'b0;
            if (xfer) bus.din <= bus.pix_data;
            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        lcu_size <= cfg_lcu_size;
                        pos_x    <= '0;
                        pos_y    <= '0;
                        px_cnt   <= '0;
                    end else if (start_bad) begin
                        err <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.prm_valid) begin
                        bus.sao_type     <= bus.prm_type;
                        bus.sao_band_pos <= bus.prm_band_pos;
                        bus.sao_eo_class <= bus.prm_eo_class;
                        bus.sao_offset   <= bus.prm_offset;
                        lcu_x            <= pos_x;
                        lcu_y            <= pos_y;
                    end
                end
                STREAM: begin
                    if (xfer) px_cnt <= px_cnt + 13'd1;
                    if (lcu_full) begin
                        px_cnt    <= '0;
                        drain_cnt <= '0;
                        if (!last_lcu) begin
                            if (pos_x == x_last) begin
                                pos_x <= '0;
                                pos_y <= pos_y + 3'd1;
                            end else begin
                                pos_x <= pos_x + 3'd1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (bus.sao_finish) begin
                        frame_done <= 1'b1;
                    end else if (drain_cnt == DRAIN_LAST) begin
                        frame_done <= 1'b1;
                        err        <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SAO_SCHED_STALL_CNT_EN
    logic [15:0] stall_q;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Only stalls caused by SAO busy count; the end-of-LCU gap is not a stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (state == IDLE) begin
            if (start) stall_q <= '0;
        end else if ((state == STREAM) && bus.pix_valid && bus.sao_busy && !lcu_full) begin
            stall_q <= sat_inc16(stall_q);
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sao_lcu_scheduler.sv
// Randomized self-checking bench for sao_lcu_scheduler; pixel/parameter streams scored against
// an index-based frame model (LCU k of a raster walk, pixel i belongs to LCU i / LCU_PIX).
module tb_sao_lcu_scheduler;
    localparam int FW  = 128;
    localparam int FH  = 128;
    localparam int DTO = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  cfg_lcu_size = 2'd0;
    logic [2:0]  lcu_x, lcu_y;
    logic [1:0]  lcu_size;
    logic        frame_done, err;
    logic [15:0] stall_cnt;

    sao_lcu_scheduler_if bus ();

    sao_lcu_scheduler #(.FRAME_W(FW), .FRAME_H(FH), .DRAIN_TO(DTO)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_lcu_size (cfg_lcu_size),
        .bus          (bus.master),
        .lcu_x        (lcu_x),
        .lcu_y        (lcu_y),
        .lcu_size     (lcu_size),
        .frame_done   (frame_done),
        .err          (err),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    logic [7:0]  pix_arr [FW*FH];
    logic [23:0] prm_arr [64];

    task automatic chk(input string tag, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.prm_valid    = 1'b0;
        bus.prm_type     = '0;
        bus.prm_band_pos = '0;
        bus.prm_eo_class = 1'b0;
        bus.prm_offset   = '0;
        bus.pix_valid    = 1'b0;
        bus.pix_data     = '0;
        bus.sao_busy     = 1'b0;
        bus.sao_finish   = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_en"}, bus.in_en, 0);
        chk({tag, "_din"}, bus.din, 0);
        chk({tag, "_params"}, {bus.sao_type, bus.sao_band_pos, bus.sao_eo_class, bus.sao_offset}, 0);
        chk({tag, "_lcu_xy"}, {lcu_x, lcu_y}, 0);
        chk({tag, "_lcu_size"}, lcu_size, 0);
        chk({tag, "_done_err"}, {frame_done, err}, 0);
        chk({tag, "_stall_cnt"}, stall_cnt, 0);
        chk({tag, "_readies"}, {bus.prm_ready, bus.pix_ready}, 0);
    endtask

    // One frame at LCU size sz. rnd: random valid/busy/param gaps; burst: 16-cycle busy
    // burst mid-LCU 1; give_fin: SAO reports finish in drain; abort_at>0: async reset there.
    task automatic run_frame(input int sz, input bit rnd, input bit give_fin,
                             input bit burst, input int abort_at);
        int  lcu_pix, ncols, nlcu, total;
        int  src_idx, prm_idx, out_idx, cyc, last_en, burst_i, fin_wait, k, lat;
        bit  acc, pacc, done, stray;
        lcu_pix = 256 << (2 * sz);
        ncols   = (FW / 16) >> sz;
        nlcu    = ncols * ((FH / 16) >> sz);
        total   = FW * FH;
        for (int i = 0; i < total; i++) pix_arr[i] = 8'($urandom);
        for (int j = 0; j < nlcu; j++) prm_arr[j] = {2'($urandom_range(0, 2)), 22'($urandom)};
        src_idx = 0; prm_idx = 0; out_idx = 0; cyc = 0; last_en = 0;
        burst_i = -1; fin_wait = 0; stray = 1'b0; done = 1'b0;

        @(posedge clk); #1;
        start = 1'b1; cfg_lcu_size = 2'(sz);
        @(posedge clk); #1;
        start = 1'b0;
        while (!done && cyc < 40000) begin
            bus.prm_valid = (prm_idx < nlcu) && (!rnd || $urandom_range(0, 3) != 0);
            {bus.prm_type, bus.prm_band_pos, bus.prm_eo_class, bus.prm_offset} =
                prm_arr[(prm_idx < nlcu) ? prm_idx : 0];
            if (burst && burst_i < 0 && src_idx == lcu_pix + 100) burst_i = 0;
            bus.sao_busy  = (burst_i >= 0 && burst_i < 16) || (rnd && $urandom_range(0, 9) == 0);
            bus.pix_valid = (src_idx < total) &&
                            ((burst_i >= 0 && burst_i < 16) || !rnd || $urandom_range(0, 3) != 0);
            bus.pix_data  = pix_arr[(src_idx < total) ? src_idx : 0];
            if (!stray && src_idx == 50) begin
                bus.sao_finish = 1'b1;
                stray = 1'b1;
            end else if (give_fin && src_idx == total) begin
                fin_wait++;
                bus.sao_finish = (fin_wait == 6);
            end else begin
                bus.sao_finish = 1'b0;
            end

            @(negedge clk);
            cyc++;
            if (bus.in_en) begin
                if (out_idx < total) begin
                    k = out_idx / lcu_pix;
                    chk("din_order", bus.din, pix_arr[out_idx]);
                    chk("lcu_params", {bus.sao_type, bus.sao_band_pos, bus.sao_eo_class, bus.sao_offset},
                        prm_arr[k]);
                    chk("lcu_x", lcu_x, k % ncols);
                    chk("lcu_y", lcu_y, k / ncols);
                    chk("lcu_size", lcu_size, sz);
                end else begin
                    chk("extra_pixel", out_idx, total - 1);
                end
                out_idx++;
                last_en = cyc;
            end
            if (bus.sao_busy) chk("busy_blocks_ready", bus.pix_ready, 0);
            if (burst_i >= 1 && burst_i <= 16) chk("burst_in_en", bus.in_en, 0);
            if (burst_i >= 0 && burst_i < 17) burst_i++;
            if (frame_done) begin
                done = 1'b1;
                lat  = cyc - last_en;
                chk("frame_err", err, give_fin ? 0 : 1);
                chk("pixels_per_frame", out_idx, total);
                chk("lcu_handshakes", prm_idx, nlcu);
                if (!give_fin) chk("drain_timeout_window", (lat >= DTO && lat <= DTO + 2) ? 1 : 0, 1);
`ifdef SAO_SCHED_STALL_CNT_EN
                if (!rnd) chk("stall_cnt", stall_cnt, burst ? 16 : 0);
`else
                chk("stall_cnt_off", stall_cnt, 0);
`endif
            end
            acc  = bus.pix_valid && bus.pix_ready;
            pacc = bus.prm_valid && bus.prm_ready;
            @(posedge clk); #1;
            if (acc) src_idx++;
            if (pacc) prm_idx++;
            if (abort_at > 0 && src_idx == abort_at) begin
                #1 reset = 1'b1;
                #1 chk_all_zero("abort");
                idle_inputs();
                @(negedge clk);
                reset = 1'b0;
                return;
            end
        end
        idle_inputs();
        if (!done) begin
            chk("frame_completes", 0, 1);
        end else begin
            @(negedge clk);
            chk("frame_done_pulse", {frame_done, err}, 0);
`ifdef SAO_SCHED_STALL_CNT_EN
            if (!rnd) chk("stall_cnt_hold", stall_cnt, burst ? 16 : 0);
`endif
        end
    endtask

    initial begin
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("post_reset");

        // Illegal LCU size: err one cycle after start, no parameter handshake offered.
        @(posedge clk); #1;
        start = 1'b1; cfg_lcu_size = 2'd3; bus.prm_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("illegal_err", err, 1);
        chk("illegal_prm_ready", bus.prm_ready, 0);
        @(negedge clk);
        chk("illegal_err_pulse", err, 0);
        chk("illegal_idle", bus.prm_ready, 0);
        @(negedge clk);
        chk("illegal_stays_idle", bus.prm_ready, 0);
        idle_inputs();

        run_frame(2, 1'b0, 1'b1, 1'b1, 0);
        run_frame(1, 1'b1, 1'b1, 1'b0, 1024 + 300);
        run_frame(1, 1'b1, 1'b1, 1'b0, 0);
        run_frame(0, 1'b1, 1'b0, 1'b0, 0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
